// File: rtl/noc_credit_link_if.sv
// Flit link between two NoC routers: forward flit fields plus a reverse credit.
// The master drives the flit and receives credits; the slave does the opposite.
interface noc_credit_link_if #(
   parameter int FLIT_WIDTH = 128,
   parameter int DEST_WIDTH = 6
);
   logic [FLIT_WIDTH-1:0] data;
   logic [DEST_WIDTH-1:0] dest;
   logic                  is_tail;
   logic                  send;
   logic                  credit;

   modport master (output data, dest, is_tail, send, input  credit);
   modport slave  (input  data, dest, is_tail, send, output credit);
endinterface

// File: rtl/noc_credit_link.sv
// Pipelined credit-based NoC link with a passive protocol monitor.
// The upstream port carries data_in/dest_in/is_tail_in/send_in and returns
// credit_out; the downstream port carries data_out/dest_out/is_tail_out/send_out
// and receives credit_in. The monitor tracks upstream credits, packet framing
// and traffic counts, and never touches the forwarded flits or credits.
module noc_credit_link #(
   parameter int FLIT_WIDTH        = 128,
   parameter int DEST_WIDTH        = 6,
   parameter int NUM_PIPELINE      = 2,
   parameter int FLIT_BUFFER_DEPTH = 8,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   noc_credit_link_if.slave                       up,
   noc_credit_link_if.master                      dn,
   input  logic                                   err_clear,
   output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0] credit_avail,
   output logic                                   err_overflow,
   output logic                                   err_underflow,
   output logic                                   err_dest,
   output logic [CNT_WIDTH-1:0]                   flit_count,
   output logic [CNT_WIDTH-1:0]                   pkt_count
);

   localparam int              CAW     = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam logic [CAW-1:0]  DEPTH_C = CAW'(FLIT_BUFFER_DEPTH);

   typedef enum logic {S_IDLE, S_BODY} state_t;

   // Monitor taps: the input-side flit and the credit as the upstream sees it
   logic                  w_send_in;
   logic                  w_tail_in;
   logic [DEST_WIDTH-1:0] w_dest_in;
   logic                  w_credit_out;

   assign w_send_in    = up.send;
   assign w_tail_in    = up.is_tail;
   assign w_dest_in    = up.dest;
   assign w_credit_out = up.credit;

   // ------------------------------------------------------------------
   // Delay lines (forward and credit, equal depth, independent)
   // ------------------------------------------------------------------
   if (NUM_PIPELINE == 0) begin : g_bypass
      assign dn.data    = up.data;
      assign dn.dest    = up.dest;
      assign dn.is_tail = up.is_tail;
      assign dn.send    = up.send;
      assign up.credit  = dn.credit;
   end else begin : g_pipe
      logic [FLIT_WIDTH-1:0]   r_data [NUM_PIPELINE];
      logic [DEST_WIDTH-1:0]   r_dest [NUM_PIPELINE];
      logic [NUM_PIPELINE-1:0] r_tail;
      logic [NUM_PIPELINE-1:0] r_send;
      logic [NUM_PIPELINE-1:0] r_credit;

      // Payload shift register; contents are don't-care while send is low
      always_ff @(posedge clk) begin
         r_data[0] <= up.data;
         r_dest[0] <= up.dest;
         r_tail[0] <= up.is_tail;
         for (int unsigned i = 1; i < NUM_PIPELINE; i++) begin
            r_data[i] <= r_data[i-1];
            r_dest[i] <= r_dest[i-1];
            r_tail[i] <= r_tail[i-1];
         end
      end

      // Valid bits for flits and credits; reset drops everything in flight
      always_ff @(posedge clk) begin
         if (rst) begin
            r_send   <= '0;
            r_credit <= '0;
         end else begin
            r_send[0]   <= up.send;
            r_credit[0] <= dn.credit;
            for (int unsigned i = 1; i < NUM_PIPELINE; i++) begin
               r_send[i]   <= r_send[i-1];
               r_credit[i] <= r_credit[i-1];
            end
         end
      end

      assign dn.data    = r_data[NUM_PIPELINE-1];
      assign dn.dest    = r_dest[NUM_PIPELINE-1];
      assign dn.is_tail = r_tail[NUM_PIPELINE-1];
      assign dn.send    = r_send[NUM_PIPELINE-1];
      assign up.credit  = r_credit[NUM_PIPELINE-1];
   end

   // ------------------------------------------------------------------
   // Upstream credit tracking
   // ------------------------------------------------------------------
   logic [CAW-1:0] r_avail;
   logic [CAW-1:0] w_avail_nxt;
   logic           w_ovf;
   logic           w_udf;

   // Next credit count; a send and a returned credit in one cycle cancel out
   always_comb begin
      w_avail_nxt = r_avail;
      w_ovf       = 1'b0;
      w_udf       = 1'b0;
      case ({w_send_in, w_credit_out})
         2'b10: begin
            if (r_avail == '0) w_ovf = 1'b1;
            else               w_avail_nxt = r_avail - CAW'(1);
         end
         2'b01: begin
            if (r_avail == DEPTH_C) w_udf = 1'b1;
            else                    w_avail_nxt = r_avail + CAW'(1);
         end
         default: ;
      endcase
   end

   // Credit count register, saturating at both ends
   always_ff @(posedge clk) begin
      if (rst) r_avail <= DEPTH_C;
      else     r_avail <= w_avail_nxt;
   end

   // ------------------------------------------------------------------
   // Packet framing tracker
   // ------------------------------------------------------------------
   state_t                r_state;
   state_t                w_state_nxt;
   logic [DEST_WIDTH-1:0] r_pkt_dest;
   logic                  w_latch;
   logic                  w_dest_err;

   // Next state: heads latch their destination, body flits must match it
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_dest_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_send_in && !w_tail_in) begin
               w_latch     = 1'b1;
               w_state_nxt = S_BODY;
            end
         end
         S_BODY: begin
            if (w_send_in) begin
               if (w_dest_in != r_pkt_dest) w_dest_err = 1'b1;
               if (w_tail_in)               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Tracker state and latched packet destination
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pkt_dest <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) r_pkt_dest <= w_dest_in;
      end
   end

   // ------------------------------------------------------------------
   // Statistics and sticky errors
   // ------------------------------------------------------------------
   logic [CNT_WIDTH-1:0] r_flit_cnt;
   logic [CNT_WIDTH-1:0] r_pkt_cnt;
   logic                 r_err_ovf;
   logic                 r_err_udf;
   logic                 r_err_dest;

   // Free-running flit/packet counters, wrapping naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flit_cnt <= '0;
         r_pkt_cnt  <= '0;
      end else begin
         if (w_send_in)              r_flit_cnt <= r_flit_cnt + CNT_WIDTH'(1);
         if (w_send_in && w_tail_in) r_pkt_cnt  <= r_pkt_cnt + CNT_WIDTH'(1);
      end
   end

   // Sticky flags; a new error wins over a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_ovf  <= 1'b0;
         r_err_udf  <= 1'b0;
         r_err_dest <= 1'b0;
      end else begin
         r_err_ovf  <= (r_err_ovf  & ~err_clear) | w_ovf;
         r_err_udf  <= (r_err_udf  & ~err_clear) | w_udf;
         r_err_dest <= (r_err_dest & ~err_clear) | w_dest_err;
      end
   end

   assign credit_avail  = r_avail;
   assign err_overflow  = r_err_ovf;
   assign err_underflow = r_err_udf;
   assign err_dest      = r_err_dest;
   assign flit_count    = r_flit_cnt;
   assign pkt_count     = r_pkt_cnt;

endmodule

// File: tb/tb_noc_credit_link.sv
// Directed bench for noc_credit_link: a 2-stage instance (A) and a
// pass-through instance (B), exercised one after the other.
module tb_noc_credit_link;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   noc_credit_link_if #(.FLIT_WIDTH(128), .DEST_WIDTH(6)) upA ();
   noc_credit_link_if #(.FLIT_WIDTH(128), .DEST_WIDTH(6)) dnA ();
   noc_credit_link_if #(.FLIT_WIDTH(128), .DEST_WIDTH(6)) upB ();
   noc_credit_link_if #(.FLIT_WIDTH(128), .DEST_WIDTH(6)) dnB ();

   logic        clrA, clrB;
   logic [3:0]  availA, availB;
   logic        ovfA, udfA, dstA, ovfB, udfB, dstB;
   logic [15:0] fcA, pcA, fcB, pcB;

   noc_credit_link #(
      .FLIT_WIDTH(128), .DEST_WIDTH(6), .NUM_PIPELINE(2),
      .FLIT_BUFFER_DEPTH(8), .CNT_WIDTH(16)
   ) dutA (
      .clk(clk), .rst(rst), .up(upA), .dn(dnA), .err_clear(clrA),
      .credit_avail(availA), .err_overflow(ovfA), .err_underflow(udfA),
      .err_dest(dstA), .flit_count(fcA), .pkt_count(pcA)
   );

   noc_credit_link #(
      .FLIT_WIDTH(128), .DEST_WIDTH(6), .NUM_PIPELINE(0),
      .FLIT_BUFFER_DEPTH(8), .CNT_WIDTH(16)
   ) dutB (
      .clk(clk), .rst(rst), .up(upB), .dn(dnB), .err_clear(clrB),
      .credit_avail(availB), .err_overflow(ovfB), .err_underflow(udfB),
      .err_dest(dstB), .flit_count(fcB), .pkt_count(pcB)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic flitA(input logic s, input logic [127:0] d, input logic [5:0] ds, input logic t);
      upA.send = s; upA.data = d; upA.dest = ds; upA.is_tail = t;
   endtask

   task automatic flitB(input logic s, input logic [127:0] d, input logic [5:0] ds, input logic t);
      upB.send = s; upB.data = d; upB.dest = ds; upB.is_tail = t;
   endtask

   initial begin
      rst = 1'b1;
      clrA = 1'b0; clrB = 1'b0;
      flitA(1'b0, '0, '0, 1'b0); dnA.credit = 1'b0;
      flitB(1'b0, '0, '0, 1'b0); dnB.credit = 1'b0;
      tick(); tick();

      // Reset state
      chk("rst_send_out",   dnA.send,   0);
      chk("rst_credit_out", upA.credit, 0);
      chk("rst_avail",      availA,     8);
      chk("rst_flit_cnt",   fcA,        0);
      chk("rst_pkt_cnt",    pcA,        0);
      chk("rst_errs",       {ovfA, udfA, dstA}, 0);
      rst = 1'b0;

      // 3-flit packet, dest 0x15, two-cycle latency
      flitA(1'b1, 128'hA0, 6'h15, 1'b0); tick();
      chk("p3_lat_c1", dnA.send, 0);
      flitA(1'b1, 128'hA1, 6'h15, 1'b0); tick();
      chk("p3_out0_send", dnA.send, 1);
      chk("p3_out0_data", dnA.data, 128'hA0);
      chk("p3_out0_tail", dnA.is_tail, 0);
      flitA(1'b1, 128'hA2, 6'h15, 1'b1); tick();
      chk("p3_out1_data", dnA.data, 128'hA1);
      chk("p3_out1_dest", dnA.dest, 6'h15);
      chk("p3_avail", availA, 5);
      chk("p3_flits", fcA, 3);
      chk("p3_pkts",  pcA, 1);
      flitA(1'b0, '0, '0, 1'b0); tick();
      chk("p3_out2_data", dnA.data, 128'hA2);
      chk("p3_out2_tail", dnA.is_tail, 1);
      chk("p3_out2_send", dnA.send, 1);
      tick();
      chk("p3_idle_send", dnA.send, 0);
      chk("p3_no_err", {ovfA, udfA, dstA}, 0);

      // Simultaneous send and credit at avail=5
      dnA.credit = 1'b1; tick();
      dnA.credit = 1'b0; tick();
      chk("sim_credit_out", upA.credit, 1);
      flitA(1'b1, 128'hB0, 6'h01, 1'b1); tick();
      flitA(1'b0, '0, '0, 1'b0);
      chk("sim_avail", availA, 5);
      chk("sim_credit_gone", upA.credit, 0);
      chk("sim_flits", fcA, 4);

      // Reset with a flit in flight discards it
      flitA(1'b1, 128'hC0, 6'h02, 1'b1); tick();
      flitA(1'b0, '0, '0, 1'b0); rst = 1'b1; tick();
      rst = 1'b0;
      chk("midrst_send_out", dnA.send, 0);
      chk("midrst_avail", availA, 8);
      chk("midrst_flits", fcA, 0);

      // Exhaust credits, then overflow
      for (int i = 0; i < 8; i++) begin
         flitA(1'b1, 128'h100 + 128'(i), 6'h00, 1'b1); tick();
      end
      chk("ex_avail0", availA, 0);
      chk("ex_no_ovf", ovfA, 0);
      chk("ex_flits", fcA, 8);
      flitA(1'b1, 128'h999, 6'h00, 1'b1); tick();
      chk("ovf_set", ovfA, 1);
      chk("ovf_avail", availA, 0);
      chk("ovf_out8", dnA.data, 128'h107);
      flitA(1'b1, 128'hAAA, 6'h00, 1'b1); clrA = 1'b1; tick();
      chk("ovf_clr_and_new", ovfA, 1);
      chk("ovf_fwd_send", dnA.send, 1);
      chk("ovf_fwd_data", dnA.data, 128'h999);
      flitA(1'b0, '0, '0, 1'b0); tick();
      clrA = 1'b0;
      chk("ovf_cleared", ovfA, 0);
      chk("ovf_last_fwd", dnA.data, 128'hAAA);
      chk("ovf_flits", fcA, 10);
      chk("ovf_pkts",  pcA, 10);

      // Underflow: credit returned while already full
      rst = 1'b1; tick(); rst = 1'b0;
      dnA.credit = 1'b1; tick();
      dnA.credit = 1'b0; tick();
      chk("udf_credit_out", upA.credit, 1);
      chk("udf_not_yet", udfA, 0);
      tick();
      chk("udf_set", udfA, 1);
      chk("udf_avail", availA, 8);
      chk("udf_credit_done", upA.credit, 0);
      clrA = 1'b1; tick(); clrA = 1'b0;
      chk("udf_cleared", udfA, 0);

      // Destination mismatch inside a packet
      flitA(1'b1, 128'h40, 6'h03, 1'b0); tick();
      flitA(1'b1, 128'h41, 6'h04, 1'b0); tick();
      chk("dst_set", dstA, 1);
      chk("dst_fwd_head", dnA.data, 128'h40);
      flitA(1'b1, 128'h42, 6'h03, 1'b1); tick();
      chk("dst_fwd_body_data", dnA.data, 128'h41);
      chk("dst_fwd_body_dest", dnA.dest, 6'h04);
      chk("dst_fwd_body_send", dnA.send, 1);
      flitA(1'b0, '0, '0, 1'b0); tick();
      chk("dst_fwd_tail", {dnA.send, dnA.is_tail, dnA.data[7:0]}, {2'b11, 8'h42});
      chk("dst_avail", availA, 5);
      chk("dst_sticky", dstA, 1);

      // Pass-through instance
      rst = 1'b1; tick(); rst = 1'b0;
      flitB(1'b1, 128'h55, 6'h05, 1'b0); #1;
      chk("pt_send", dnB.send, 1);
      chk("pt_data", dnB.data, 128'h55);
      chk("pt_dest", dnB.dest, 6'h05);
      tick();
      flitB(1'b0, '0, '0, 1'b0); dnB.credit = 1'b1; #1;
      chk("pt_credit", upB.credit, 1);
      chk("pt_avail7", availB, 7);
      tick();
      dnB.credit = 1'b0;
      chk("pt_avail8", availB, 8);
      flitB(1'b1, 128'h56, 6'h05, 1'b0); tick();
      chk("pt_avail_body", availB, 7);
      flitB(1'b0, '0, '0, 1'b0); rst = 1'b1; tick(); rst = 1'b0;
      chk("pt_rst_send", dnB.send, 0);
      chk("pt_rst_avail", availB, 8);
      flitB(1'b1, 128'h60, 6'h09, 1'b0); tick();
      chk("pt_newhead_nodst", dstB, 0);
      flitB(1'b1, 128'h61, 6'h09, 1'b1); tick();
      flitB(1'b0, '0, '0, 1'b0);
      chk("pt_pkts", pcB, 1);
      chk("pt_flits", fcB, 2);
      chk("pt_nodst", dstB, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
